cpu6_memarb: RTL and testbench
==============================

# cpu6_memarb

Single-outstanding arbiter between the cpu6 instruction-fetch port and the MEM-stage load/store port. It drives one shared memory bus. The datapath's `dataaddrM` / `writedataM` / `memwriteM` / `readdataM` connect to the LS side, and the fetch unit connects to the IF side. It sequences each transaction through request, grant and response, and returns the read data to the owning requester. It also produces the busy indication the pipeline uses to stall.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `MAX_LS_STREAK`, 4, consecutive LS grants allowed while IF waits (fairness build only); legal range 1..15

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  XLEN  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch data valid this cycle
- `if_rdata`  out  XLEN  fetch data (= `mem_rdata`)
- `ls_req`  in  1  load/store request; held with all ls_* fields stable until `ls_gnt`
- `ls_we`  in  1  1 = store
- `ls_addr`  in  XLEN  data address
- `ls_wdata`  in  XLEN  store data
- `ls_be`  in  XLEN/8  byte enables
- `ls_gnt`  out  1  load/store accepted this cycle
- `ls_rvalid`  out  1  load data / store ack valid this cycle
- `ls_rdata`  out  XLEN  load data (= `mem_rdata`)
- `mem_req`  out  1  bus request
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/XLEN/XLEN/XLEN/8  bus command
- `mem_gnt`  in  1  bus accepts command this cycle
- `mem_rvalid`  in  1  response (read data or write ack)
- `mem_rdata`  in  XLEN  read data
- `busy`  out  1  state ≠ IDLE

## Operation
States: IDLE, REQ, RSP.

IDLE:
- `mem_req = if_req | ls_req`.
- Owner is chosen combinationally: LS wins by default. IF wins if only IF requests, or if fairness forces it.
- The mem_* command is muxed from the owner.
- If `mem_gnt` is high: pulse the owner's gnt and go to RSP. Otherwise latch the owner and go to REQ.
- If no request, stay in IDLE.

REQ:
- `mem_req = 1`; the command comes from the latched owner.
- The owner is locked even if the other requester rises.
- On `mem_gnt`: pulse the owner's gnt and go to RSP.

RSP:
- `mem_req = 0`.
- On `mem_rvalid`: assert the owner's rvalid and go to IDLE.

Response routing:
- `mem_rvalid` outside RSP is ignored: no requester rvalid is asserted.
- `if_rdata` / `ls_rdata` always carry `mem_rdata` and are qualified only by rvalid.
- Stores receive `ls_rvalid` as the write ack; `ls_rdata` is don't-care in that case.
- gnt and rvalid are each asserted to at most one requester per cycle.

Reset:
- Reset (low) at any time forces IDLE, the streak counter to 0 and the owner to IF.
- All outputs go low: `mem_req`, the gnt and rvalid outputs, and `busy`.
- mem_* command and rdata outputs are 0 / pass-through.
- Any outstanding transaction is abandoned; its late `mem_rvalid` is ignored.

## Timing
- Arbitration decision and `mem_req` are combinational in IDLE, so there is zero-cycle issue.
- gnt is combinational from `mem_gnt` (same cycle).
- rvalid is combinational from `mem_rvalid` (same cycle).
- Minimum transaction is 2 cycles (IDLE with gnt, then RSP with rvalid). The next arbitration happens in the cycle after rvalid, so peak throughput is 1 transaction per 2 cycles.
- A requester deasserting req before gnt is a protocol violation; behaviour is undefined.
- If both requests rise in the same cycle, LS is granted; IF stays pending and is serviced in the next IDLE.

## Configuration
Macro `CPU6_MEMARB_FAIRNESS_EN`.

Defined:
- A 4-bit `ls_streak` counter increments on each LS grant issued while `if_req` is high.
- It clears on any IF grant, and also clears on an LS grant with `if_req` low.
- When `ls_streak == MAX_LS_STREAK` and `if_req` is high, IF wins the next IDLE arbitration.
- The counter saturates and never wraps.

Undefined:
- Strict LS priority; IF can starve indefinitely.
- No counter logic is present.

## Test plan
- Reset asserted mid-RSP (owner LS) → all outputs low immediately; `mem_rvalid=1` one cycle after release gives no `ls_rvalid` or `if_rvalid`; next `if_req` is granted normally.
- Only `if_req`, `if_addr=0x100`, memory gnt same cycle, rvalid next cycle with `0xDEADBEEF` → `if_gnt` in cycle 0, `if_rvalid`/`if_rdata=0xDEADBEEF` in cycle 1, `busy` high only in cycle 1.
- `if_req` and `ls_req` (store, addr `0x2000`, data `0x55`, be `0xF`) in the same cycle → `mem_we=1`, `mem_addr=0x2000`, `ls_gnt`; IF is granted in the first IDLE after `ls_rvalid`.
- Memory holds `mem_gnt` low for 3 cycles while IF owns REQ and `ls_req` rises → `mem_addr` stays at the IF address all 3 cycles; LS is granted only after the IF response.
- Fairness defined, `MAX_LS_STREAK=4`, `ls_req` and `if_req` continuously high → exactly 4 LS transactions, then 1 IF, repeating.
- Same stimulus with fairness undefined → LS only, `if_gnt` never asserted.
- Stray `mem_rvalid` pulse while IDLE → no rvalid to either requester; state stays IDLE.

Source files
------------

// File: rtl/cpu6_memarb_if.sv
// cpu6_memarb_if: fetch, load/store and shared memory bus signals.
// master = arbiter side, slave = requesters plus memory.
interface cpu6_memarb_if #(
  parameter int XLEN = 32
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [XLEN-1:0]   ls_addr;
  logic [XLEN-1:0]   ls_wdata;
  logic [XLEN/8-1:0] ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [XLEN-1:0]   ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cpu6_memarb.sv
// cpu6_memarb: single-outstanding IF/LS arbiter onto one memory bus.
// Define CPU6_MEMARB_FAIRNESS_EN to bound LS streaks while IF waits.
module cpu6_memarb #(
  parameter int XLEN          = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  cpu6_memarb_if.master bus,
  output logic          busy
);
  localparam int BW = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nx;
  logic       r_own_ls;
  logic       w_own_ls;
  logic       w_pick_ls;
  logic       w_force_if;
  logic       w_req;
  logic       w_gnt;
  logic       w_rsp;

`ifdef CPU6_MEMARB_FAIRNESS_EN
  localparam logic [3:0] MAX_S = 4'(MAX_LS_STREAK);

  logic [3:0] r_streak;

  assign w_force_if = bus.if_req && (r_streak == MAX_S);
`else
  assign w_force_if = 1'b0 && (MAX_LS_STREAK > 0);
`endif

  // LS wins unless absent or the fairness limit hands the slot to IF
  assign w_pick_ls = bus.ls_req && !w_force_if;
  assign w_own_ls  = (r_state == S_IDLE) ? w_pick_ls : r_own_ls;

  // Bus request: live in IDLE, held in REQ, dropped in RSP and reset
  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      S_IDLE:  w_req = bus.if_req | bus.ls_req;
      S_REQ:   w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
    if (!reset) w_req = 1'b0;
  end

  assign w_gnt = w_req && bus.mem_gnt;
  assign w_rsp = reset && (r_state == S_RSP) && bus.mem_rvalid;

  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_req && w_own_ls && bus.ls_we;
  assign bus.mem_addr  = !w_req   ? {XLEN{1'b0}} :
                         w_own_ls ? bus.ls_addr : bus.if_addr;
  assign bus.mem_wdata = (w_req && w_own_ls) ? bus.ls_wdata : {XLEN{1'b0}};
  assign bus.mem_be    = !w_req   ? {BW{1'b0}} :
                         w_own_ls ? bus.ls_be : {BW{1'b1}};

  assign bus.if_gnt    = w_gnt && !w_own_ls;
  assign bus.ls_gnt    = w_gnt && w_own_ls;
  assign bus.if_rvalid = w_rsp && !r_own_ls;
  assign bus.ls_rvalid = w_rsp && r_own_ls;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  assign busy = (r_state != S_IDLE);

  // Transaction sequencing: request, grant, response
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_state_nx = bus.mem_gnt ? S_RSP : S_REQ;
      S_REQ:   if (bus.mem_gnt) w_state_nx = S_RSP;
      S_RSP:   if (bus.mem_rvalid) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and owner lock; owner is fixed from issue until response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_own_ls <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && w_req) r_own_ls <= w_pick_ls;
    end
  end

`ifdef CPU6_MEMARB_FAIRNESS_EN
  // Count LS grants taken while IF waits; saturate at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= 4'd0;
    end else if (w_gnt) begin
      if (!w_own_ls || !bus.if_req) r_streak <= 4'd0;
      else if (r_streak != MAX_S) r_streak <= r_streak + 4'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cpu6_memarb.sv
// tb_cpu6_memarb: directed scenarios plus a randomized run
// against a transaction-level model of the arbiter.
module tb_cpu6_memarb;
  localparam int XL   = 32;
  localparam int MAXS = 4;
`ifdef CPU6_MEMARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  cpu6_memarb_if #(.XLEN(XL)) bus ();

  cpu6_memarb #(
    .XLEN(XL),
    .MAX_LS_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_in();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.ls_be      = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    reset = 1'b0;
    clear_in();
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    bus.mem_gnt = 1'b1;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    o = {bus.mem_req, bus.if_gnt, bus.ls_gnt,
         bus.if_rvalid, bus.ls_rvalid, busy};
    checks++;
    if (o !== 6'b0) begin
      errors++;
      $display("FAIL reset_held: outs %b exp 000000", o);
    end
    next();
    reset = 1'b1;
    clear_in();
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h40;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ls_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_ls_gnt: got %b exp 1", bus.ls_gnt);
    end
    next();
    clear_in();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_rsp_busy: got %b exp 1", busy);
    end
    #1;
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    #1;
    o = {bus.mem_req, bus.if_gnt, bus.ls_gnt,
         bus.if_rvalid, bus.ls_rvalid, busy};
    checks++;
    if (o !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_rsp: outs %b exp 000000", o);
    end
    next();
    reset = 1'b1;
    clear_in();
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    o = {3'b0, bus.if_rvalid, bus.ls_rvalid, busy};
    checks++;
    if (o !== 6'b0) begin
      errors++;
      $display("FAIL late_rvalid: outs %b exp 000000", o);
    end
    next();
    clear_in();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_addr} !== {2'b10, 32'h100}) begin
      errors++;
      $display("FAIL post_rst_if: gnt %b%b addr %h exp 10 00000100",
               bus.if_gnt, bus.ls_gnt, bus.mem_addr);
    end
    next();
    clear_in();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL post_rst_rsp: rv %b data %h exp 1 12345678",
               bus.if_rvalid, bus.if_rdata);
    end
    next();
    clear_in();
  endtask

  task automatic test_if_single();
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.if_gnt, busy, bus.mem_addr, bus.mem_we} !==
        {3'b110, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL if_c0: req %b gnt %b busy %b addr %h we %b",
               bus.mem_req, bus.if_gnt, busy, bus.mem_addr, bus.mem_we);
    end
    next();
    clear_in();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid, busy, bus.mem_req, bus.if_rdata} !==
        {4'b1010, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL if_c1: rv %b%b busy %b req %b data %h exp 1010 deadbeef",
               bus.if_rvalid, bus.ls_rvalid, busy, bus.mem_req, bus.if_rdata);
    end
    next();
    clear_in();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL if_c2_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h300;
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b1;
    bus.ls_addr = 32'h2000;
    bus.ls_wdata = 32'h55;
    bus.ls_be = 4'hF;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
         bus.ls_gnt, bus.if_gnt} !==
        {1'b1, 32'h2000, 32'h55, 4'hF, 2'b10}) begin
      errors++;
      $display("FAIL both_st: we %b a %h d %h be %h gnt ls%b if%b",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
               bus.ls_gnt, bus.if_gnt);
    end
    next();
    bus.ls_req = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ls_rvalid, bus.if_rvalid, bus.if_gnt, bus.mem_req} !==
        4'b1000) begin
      errors++;
      $display("FAIL both_ack: ls_rv %b if_rv %b if_gnt %b req %b exp 1000",
               bus.ls_rvalid, bus.if_rvalid, bus.if_gnt, bus.mem_req);
    end
    next();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_we, bus.mem_addr} !==
        {3'b100, 32'h300}) begin
      errors++;
      $display("FAIL both_if: gnt if%b ls%b we %b a %h exp 100 300",
               bus.if_gnt, bus.ls_gnt, bus.mem_we, bus.mem_addr);
    end
    next();
    clear_in();
    bus.mem_rvalid = 1'b1;
    next();
    clear_in();
  endtask

  task automatic test_locked_owner();
    do_reset();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h400;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.ls_req = 1'b1;
        bus.ls_addr = 32'h3000;
      end
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_addr, bus.if_gnt, bus.ls_gnt} !==
          {1'b1, 32'h400, 2'b00}) begin
        errors++;
        $display("FAIL lock_c%0d: req %b a %h gnt %b%b exp 1 400 00",
                 c, bus.mem_req, bus.mem_addr, bus.if_gnt, bus.ls_gnt);
      end
      next();
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_addr} !== {2'b10, 32'h400}) begin
      errors++;
      $display("FAIL lock_gnt: gnt %b%b a %h exp 10 400",
               bus.if_gnt, bus.ls_gnt, bus.mem_addr);
    end
    next();
    bus.if_req = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid, bus.ls_gnt} !== 3'b100) begin
      errors++;
      $display("FAIL lock_rsp: rv %b%b ls_gnt %b exp 100",
               bus.if_rvalid, bus.ls_rvalid, bus.ls_gnt);
    end
    next();
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ls_gnt, bus.mem_addr} !== {1'b1, 32'h3000}) begin
      errors++;
      $display("FAIL lock_ls: gnt %b a %h exp 1 3000",
               bus.ls_gnt, bus.mem_addr);
    end
    next();
    clear_in();
    bus.mem_rvalid = 1'b1;
    next();
    clear_in();
  endtask

  task automatic test_fairness();
    bit e_if;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      e_if = FAIR && ((i % (MAXS + 1)) == MAXS);
      bus.if_req = 1'b1;
      bus.ls_req = 1'b1;
      bus.if_addr = 32'h1000 + 32'(i * 4);
      bus.ls_addr = 32'h8000 + 32'(i * 4);
      bus.mem_gnt = 1'b1;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {e_if, !e_if}) begin
        errors++;
        $display("FAIL fair_gnt%0d: if/ls %b%b exp %b%b",
                 i, bus.if_gnt, bus.ls_gnt, e_if, !e_if);
      end
      next();
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.if_rvalid, bus.ls_rvalid} !== {e_if, !e_if}) begin
        errors++;
        $display("FAIL fair_rv%0d: if/ls %b%b exp %b%b",
                 i, bus.if_rvalid, bus.ls_rvalid, e_if, !e_if);
      end
      next();
    end
    clear_in();
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hCAFE0001;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid, busy, bus.mem_req} !== 4'b0) begin
      errors++;
      $display("FAIL stray: rv %b%b busy %b req %b exp 0000",
               bus.if_rvalid, bus.ls_rvalid, busy, bus.mem_req);
    end
    next();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: busy %b exp 0", busy);
    end
    next();
  endtask

  task automatic test_random(input int n);
    bit        if_pend, ls_pend, lwe, granted, rsp, e_req, e_g;
    bit        gnt, rv;
    logic [31:0] ia, la, lw, rd, e_addr;
    logic [3:0]  lbe;
    logic [5:0]  e_o, o;
    int        own, e_own, streak;
    do_reset();
    if_pend = 0;
    ls_pend = 0;
    own = -1;
    granted = 0;
    streak = 0;
    ia = 0;
    la = 0;
    lw = 0;
    lwe = 0;
    lbe = 0;
    for (int c = 0; c < n; c++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_pend && $urandom_range(0, 1) == 0) begin
        ls_pend = 1;
        la = $urandom;
        lw = $urandom;
        lwe = 1'($urandom_range(0, 1));
        lbe = 4'($urandom_range(1, 15));
      end
      gnt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) == 0);
      rd = $urandom;
      bus.if_req = if_pend;
      bus.if_addr = ia;
      bus.ls_req = ls_pend;
      bus.ls_addr = la;
      bus.ls_wdata = lw;
      bus.ls_we = lwe;
      bus.ls_be = lbe;
      bus.mem_gnt = gnt;
      bus.mem_rvalid = rv;
      bus.mem_rdata = rd;
      rsp = (own >= 0) && granted;
      if (own >= 0) e_own = own;
      else if (ls_pend && !(FAIR && if_pend && streak == MAXS)) e_own = 1;
      else if (if_pend) e_own = 0;
      else e_own = -1;
      e_req = (own < 0) ? (e_own >= 0) : !granted;
      e_g = e_req && gnt;
      e_o = {e_req, e_g && e_own == 0, e_g && e_own == 1,
             rsp && rv && own == 0, rsp && rv && own == 1, own >= 0};
      e_addr = (e_own == 1) ? la : ia;
      @(negedge clk);
      o = {bus.mem_req, bus.if_gnt, bus.ls_gnt,
           bus.if_rvalid, bus.ls_rvalid, busy};
      checks++;
      if (o !== e_o) begin
        errors++;
        $display("FAIL rnd_ctl c%0d: req/gi/gl/ri/rl/busy %b exp %b",
                 c, o, e_o);
      end
      if (e_req) begin
        checks++;
        if ({bus.mem_addr, bus.mem_we} !==
            {e_addr, (e_own == 1) && lwe}) begin
          errors++;
          $display("FAIL rnd_cmd c%0d: a %h we %b exp %h %b", c,
                   bus.mem_addr, bus.mem_we, e_addr, (e_own == 1) && lwe);
        end
      end
      if (rsp && rv) begin
        checks++;
        if ({bus.if_rdata, bus.ls_rdata} !== {rd, rd}) begin
          errors++;
          $display("FAIL rnd_rdata c%0d: %h/%h exp %h", c,
                   bus.if_rdata, bus.ls_rdata, rd);
        end
      end
      if (rsp && rv) begin
        own = -1;
        granted = 0;
      end else if (e_req) begin
        own = e_own;
        if (e_g) begin
          granted = 1;
          if (e_own == 1 && if_pend) streak = (streak < MAXS) ? streak + 1 : MAXS;
          else streak = 0;
          if (e_own == 1) ls_pend = 0;
          else if_pend = 0;
        end
      end
      next();
    end
    clear_in();
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    @(negedge clk);
    test_reset();
    test_if_single();
    test_same_cycle();
    test_locked_owner();
    test_fairness();
    test_stray_rvalid();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
